// File: rtl/bcd_pkg.sv
// Shared types and segment encodings for the single-digit seven-segment decoder.
// Encodings are {g,f,e,d,c,b,a}, active-low for a common-anode display.
package bcd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

    localparam seg_t SEG_HEX_A = 7'h08;
    localparam seg_t SEG_HEX_B = 7'h03;
    localparam seg_t SEG_HEX_C = 7'h46;
    localparam seg_t SEG_HEX_D = 7'h21;
    localparam seg_t SEG_HEX_E = 7'h06;
    localparam seg_t SEG_HEX_F = 7'h0E;

    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam seg_t SEG_ALL_ON = 7'h00;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational code-to-segment lookup. Define BCD_HEX_EN to show A..F glyphs
// for codes 10..15; otherwise those codes blank the digit.
module bcd_seg_lut
    import bcd_pkg::*;
(
    input  logic [3:0] bcdinput,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcdinput)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef BCD_HEX_EN
            4'd10: seg = SEG_HEX_A;
            4'd11: seg = SEG_HEX_B;
            4'd12: seg = SEG_HEX_C;
            4'd13: seg = SEG_HEX_D;
            4'd14: seg = SEG_HEX_E;
            4'd15: seg = SEG_HEX_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg = SEG_BLANK;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd.sv
// Registered BCD-to-seven-segment decoder with lamp test, blanking and an
// invalid-code flag. Hex glyphs for 10..15 are enabled by BCD_HEX_EN.
module bcd
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcdinput,
    input  logic       lamp_test,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       invalid
);

    seg_t lut_seg;
    seg_t seg_next;

    bcd_seg_lut u_lut (
        .bcdinput (bcdinput),
        .seg      (lut_seg)
    );

    // Lamp test beats blanking so a blanked display can still be lamp-tested.
    always_comb begin
        seg_next = lut_seg;
        if (lamp_test) begin
            seg_next = SEG_ALL_ON;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= SEG_BLANK;
            invalid <= 1'b0;
        end else begin
            seg     <= seg_next;
            invalid <= (bcdinput > BCD_MAX);
        end
    end

endmodule

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: directed checks from the test plan plus random
// stimulus compared every cycle against a table-driven model.
module tb_bcd;

    logic       clk;
    logic       rst;
    logic [3:0] bcdinput;
    logic       lamp_test;
    logic       blank;
    logic [6:0] seg;
    logic       invalid;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    bcd dut (
        .clk       (clk),
        .rst       (rst),
        .bcdinput  (bcdinput),
        .lamp_test (lamp_test),
        .blank     (blank),
        .seg       (seg),
        .invalid   (invalid)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst       = 1'b1;
        bcdinput  = 4'd8;
        lamp_test = 1'b0;
        blank     = 1'b0;
    end

    // reference model: glyph table straight from the display definition
    function automatic logic [7:0] model(input logic [3:0] code, input logic lt,
                                         input logic bl, input logic r);
        logic [6:0] glyph [16];
        logic [6:0] s;
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10;
`ifdef BCD_HEX_EN
        glyph[10] = 7'h08; glyph[11] = 7'h03; glyph[12] = 7'h46;
        glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'h7F;
`endif
        if (r) return {1'b0, 7'h7F};
        if (lt)      s = 7'h00;
        else if (bl) s = 7'h7F;
        else         s = glyph[code];
        return {(int'(code) > 9), s};
    endfunction

    // scoreboard: predict at each edge, compare on the following falling edge
    always @(posedge clk) begin
        exp_q.push_back(model(bcdinput, lamp_test, blank, rst));
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({invalid, seg} !== e) begin
                bad++;
                $display("FAIL model t=%0t got inv=%0b seg=%02h want inv=%0b seg=%02h",
                         $time, invalid, seg, e[7], e[6:0]);
            end
        end
    end

    // driver tasks: called at a falling edge, return one cycle later
    task automatic drive(input logic [3:0] code, input logic lt, input logic bl,
                         input logic r);
        bcdinput  = code;
        lamp_test = lt;
        blank     = bl;
        rst       = r;
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [6:0] want_seg,
                             input logic want_inv);
        #1;
        total++;
        if (seg !== want_seg || invalid !== want_inv) begin
            bad++;
            $display("FAIL %s got inv=%0b seg=%02h want inv=%0b seg=%02h",
                     name, invalid, seg, want_inv, want_seg);
        end
    endtask

    initial begin
        @(negedge clk);
        // reset held for two cycles with code 8 on the input
        drive(4'd8, 1'b0, 1'b0, 1'b1);
        drive(4'd8, 1'b0, 1'b0, 1'b1);
        check_lit("reset", 7'h7F, 1'b0);
        drive(4'd8, 1'b0, 1'b0, 1'b0);
        check_lit("release_8", 7'h00, 1'b0);

        // full sweep; model checks every code, literals pin a few entries
        for (int c = 0; c < 16; c++) begin
            drive(4'(c), 1'b0, 1'b0, 1'b0);
            if (c == 0)  check_lit("sweep_0", 7'h40, 1'b0);
            if (c == 7)  check_lit("sweep_7", 7'h78, 1'b0);
            if (c == 9)  check_lit("sweep_9", 7'h10, 1'b0);
`ifdef BCD_HEX_EN
            if (c == 10) check_lit("sweep_10", 7'h08, 1'b1);
            if (c == 15) check_lit("sweep_15", 7'h0E, 1'b1);
`else
            if (c == 10) check_lit("sweep_10", 7'h7F, 1'b1);
            if (c == 15) check_lit("sweep_15", 7'h7F, 1'b1);
`endif
        end

        drive(4'd12, 1'b1, 1'b0, 1'b0);
        check_lit("lamp_test", 7'h00, 1'b1);
        drive(4'd3, 1'b0, 1'b1, 1'b0);
        check_lit("blank", 7'h7F, 1'b0);
        drive(4'd3, 1'b1, 1'b1, 1'b0);
        check_lit("lamp_over_blank", 7'h00, 1'b0);
        drive(4'd11, 1'b0, 1'b1, 1'b0);
        check_lit("blank_invalid", 7'h7F, 1'b1);

        // mid-operation reset while showing 5
        drive(4'd5, 1'b0, 1'b0, 1'b0);
        check_lit("show_5", 7'h12, 1'b0);
        drive(4'd5, 1'b0, 1'b0, 1'b1);
        check_lit("mid_reset", 7'h7F, 1'b0);
        drive(4'd5, 1'b0, 1'b0, 1'b0);
        check_lit("after_reset_5", 7'h12, 1'b0);

        // random stimulus, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 29) == 0));
        end

        drive(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
